// File: rtl/twiddle_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : twiddle_seq                                                   |
// | Brief    : Streams radix-2 FFT twiddles W_N^e per butterfly, per stage.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module twiddle_seq #(
  parameter int LOG2N = 3,
  parameter int WIDTH = 12,
  parameter     MODE  = "DIF"
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  tw_ready,
  output logic                                  tw_valid,
  output logic signed [WIDTH-1:0]               tw_re,
  output logic signed [WIDTH-1:0]               tw_im,
  output logic [((LOG2N > 2) ? $clog2(LOG2N) : 1)-1:0] tw_stage,
  output logic [LOG2N-2:0]                      tw_index,
  output logic                                  busy,
  output logic                                  done
);

  localparam int  SW     = (LOG2N > 2) ? $clog2(LOG2N) : 1;
  localparam int  IW     = LOG2N - 1;
  localparam int  N      = 1 << LOG2N;
  localparam int  QTR    = N / 4;
  localparam int  FRAC   = WIDTH - 2;
  localparam bit  IS_DIT = (MODE == "DIT");
  localparam real PI     = 3.14159265358979323846;

  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [IW-1:0] K_LAST = '1;
  localparam logic [IW-1:0] ALL1   = '1;
  localparam logic [IW-1:0] QTR_I  = IW'(QTR);

  if (!(MODE == "DIF" || MODE == "DIT")) begin : g_bad_mode
    $error("twiddle_seq: MODE must be \"DIF\" or \"DIT\"");
  end
  if (LOG2N < 2 || LOG2N > 12) begin : g_bad_log2n
    $error("twiddle_seq: LOG2N must be in 2..12");
  end

  // Elaboration-time quarter-wave cosine, rounded half away from zero.
  function automatic logic signed [WIDTH-1:0] cos_entry(input int i);
    real v;
    v = $cos(2.0 * PI * real'(i) / real'(N)) * (2.0 ** FRAC);
    if (v >= 0.0) v = $floor(v + 0.5);
    else          v = -$floor(-v + 0.5);
    return WIDTH'($rtoi(v));
  endfunction

  logic signed [WIDTH-1:0] w_cos [0:QTR];
  for (genvar g = 0; g <= QTR; g++) begin : g_cos
    assign w_cos[g] = cos_entry(g);
  end

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           s_q, s_d;
  logic [IW-1:0]           k_q, k_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic signed [WIDTH-1:0] re_q, re_d;
  logic signed [WIDTH-1:0] im_q, im_d;
  logic                    load;
  logic [IW-1:0]           w_e, w_ep;
  logic signed [WIDTH-1:0] w_re, w_im;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          s_d     = '0;
          k_d     = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (valid_q && tw_ready) begin
          if (s_q == S_LAST && k_q == K_LAST) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            load = 1'b1;
            if (k_q == K_LAST) begin
              k_d = '0;
              s_d = s_q + 1'b1;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    re_d = load ? w_re : re_q;
    im_d = load ? w_im : im_q;
  end

  // Twiddle for the entry about to be registered (next s,k).
  assign w_e  = IS_DIT ? ((k_d & ~(ALL1 << s_d)) << (IW - int'(s_d)))
                       : ((k_d & (ALL1 >> s_d)) << s_d);
  assign w_ep = w_e - QTR_I;

  always_comb begin
    w_re = '0;
    w_im = '0;
    if (w_e < QTR_I) begin
      w_re = w_cos[w_e];
      w_im = -w_cos[QTR_I - w_e];
    end else begin
      w_re = -w_cos[QTR_I - w_ep];
      w_im = -w_cos[w_ep];
    end
  end

  assign tw_valid = valid_q;
  assign tw_re    = re_q;
  assign tw_im    = im_q;
  assign tw_stage = s_q;
  assign tw_index = k_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_twiddle_seq                                                |
// | Brief    : Directed self-checking bench for twiddle_seq.                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_twiddle_seq;

  logic clk = 1'b0;
  logic reset, start, tw_ready;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic               a_valid, a_busy, a_done;
  logic signed [11:0] a_re, a_im;
  logic [1:0]         a_stage, a_index;
  logic               b_valid, b_busy, b_done;
  logic signed [11:0] b_re, b_im;
  logic [1:0]         b_stage, b_index;
  logic               c_valid, c_busy, c_done;
  logic signed [15:0] c_re, c_im;
  logic [1:0]         c_stage;
  logic [2:0]         c_index;

  twiddle_seq #(.LOG2N(3), .WIDTH(12), .MODE("DIF")) dut_dif (
    .clk(clk), .reset(reset), .start(start), .tw_ready(tw_ready),
    .tw_valid(a_valid), .tw_re(a_re), .tw_im(a_im), .tw_stage(a_stage),
    .tw_index(a_index), .busy(a_busy), .done(a_done));

  twiddle_seq #(.LOG2N(3), .WIDTH(12), .MODE("DIT")) dut_dit (
    .clk(clk), .reset(reset), .start(start), .tw_ready(tw_ready),
    .tw_valid(b_valid), .tw_re(b_re), .tw_im(b_im), .tw_stage(b_stage),
    .tw_index(b_index), .busy(b_busy), .done(b_done));

  twiddle_seq #(.LOG2N(4), .WIDTH(16), .MODE("DIF")) dut_16 (
    .clk(clk), .reset(reset), .start(start), .tw_ready(tw_ready),
    .tw_valid(c_valid), .tw_re(c_re), .tw_im(c_im), .tw_stage(c_stage),
    .tw_index(c_index), .busy(c_busy), .done(c_done));

  int dif_re_t[12] = '{1024, 724, 0, -724, 1024, 0, 1024, 0, 1024, 1024, 1024, 1024};
  int dif_im_t[12] = '{0, -724, -1024, -724, 0, -1024, 0, -1024, 0, 0, 0, 0};
  int dit_re_t[12] = '{1024, 1024, 1024, 1024, 1024, 0, 1024, 0, 1024, 724, 0, -724};
  int dit_im_t[12] = '{0, 0, 0, 0, 0, -1024, 0, -1024, 0, -724, -1024, -724};

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; tw_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; tw_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({a_valid, a_busy, a_done, a_re, a_im, a_stage, a_index} !== '0)
      begin n_fail++; $display("FAIL reset_dif: got v=%0b b=%0b d=%0b re=%0d im=%0d s=%0d k=%0d, expected all 0",
        a_valid, a_busy, a_done, a_re, a_im, a_stage, a_index); end
    n_tests++;
    if ({b_valid, b_busy, b_done, b_re, b_im, b_stage, b_index, c_valid, c_busy, c_done,
         c_re, c_im, c_stage, c_index} !== '0)
      begin n_fail++; $display("FAIL reset_dit_16: got dit re=%0d im=%0d v=%0b, n16 re=%0d im=%0d v=%0b, expected all 0",
        b_re, b_im, b_valid, c_re, c_im, c_valid); end
    #1 reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0)
      begin n_fail++; $display("FAIL idle_after_reset: got v=%0b b=%0b d=%0b, expected 0 0 0",
        a_valid, a_busy, a_done); end
  endtask

  task automatic test_dif();
    do_reset();
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (a_valid !== 1'b1 || a_busy !== 1'b1 || a_re !== 12'(dif_re_t[i]) || a_im !== 12'(dif_im_t[i]) ||
          a_stage !== 2'(i / 4) || a_index !== 2'(i % 4))
        begin n_fail++; $display("FAIL dif_entry_%0d: got v=%0b re=%0d im=%0d s=%0d k=%0d, expected v=1 re=%0d im=%0d s=%0d k=%0d",
          i, a_valid, a_re, a_im, a_stage, a_index, dif_re_t[i], dif_im_t[i], i / 4, i % 4); end
    end
    @(negedge clk);
    n_tests++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_valid !== 1'b0)
      begin n_fail++; $display("FAIL dif_done: got d=%0b b=%0b v=%0b, expected d=1 b=0 v=0",
        a_done, a_busy, a_valid); end
    @(negedge clk);
    n_tests++;
    if (a_done !== 1'b0)
      begin n_fail++; $display("FAIL dif_done_pulse: got d=%0b, expected 0", a_done); end
  endtask

  task automatic test_dit();
    do_reset();
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (b_valid !== 1'b1 || b_re !== 12'(dit_re_t[i]) || b_im !== 12'(dit_im_t[i]) ||
          b_stage !== 2'(i / 4) || b_index !== 2'(i % 4))
        begin n_fail++; $display("FAIL dit_entry_%0d: got v=%0b re=%0d im=%0d s=%0d k=%0d, expected v=1 re=%0d im=%0d s=%0d k=%0d",
          i, b_valid, b_re, b_im, b_stage, b_index, dit_re_t[i], dit_im_t[i], i / 4, i % 4); end
    end
    @(negedge clk);
    n_tests++;
    if (b_done !== 1'b1 || b_busy !== 1'b0 || b_valid !== 1'b0)
      begin n_fail++; $display("FAIL dit_done: got d=%0b b=%0b v=%0b, expected d=1 b=0 v=0",
        b_done, b_busy, b_valid); end
  endtask

  task automatic test_back_pressure();
    int  idx   = 0;
    int  vcyc  = 0;
    int  stall = 0;
    bit  seen  = 1'b0;
    do_reset();
    pulse_start();
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (a_valid === 1'b1) begin
        vcyc++;
        n_tests++;
        if (idx > 11 || a_re !== 12'(dif_re_t[idx]) || a_im !== 12'(dif_im_t[idx]) ||
            a_stage !== 2'(idx / 4) || a_index !== 2'(idx % 4))
          begin n_fail++; $display("FAIL bp_entry_%0d: got re=%0d im=%0d s=%0d k=%0d, expected re=%0d im=%0d s=%0d k=%0d",
            idx, a_re, a_im, a_stage, a_index, dif_re_t[idx % 12], dif_im_t[idx % 12], idx / 4, idx % 4); end
        if (idx == 5 && stall < 3) begin
          tw_ready = 1'b0;
          stall++;
        end else begin
          tw_ready = 1'b1;
          idx++;
        end
      end else if (a_done === 1'b1) begin
        seen = 1'b1;
      end
    end
    tw_ready = 1'b1;
    n_tests++;
    if (!seen || vcyc != 15 || idx != 12)
      begin n_fail++; $display("FAIL bp_frame_len: got done_seen=%0b valid_cycles=%0d transfers=%0d, expected 1 15 12",
        seen, vcyc, idx); end
  endtask

  task automatic test_start_ignored();
    do_reset();
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = (i == 2);
      n_tests++;
      if (a_valid !== 1'b1 || a_re !== 12'(dif_re_t[i]) || a_im !== 12'(dif_im_t[i]) ||
          a_stage !== 2'(i / 4) || a_index !== 2'(i % 4))
        begin n_fail++; $display("FAIL busy_start_entry_%0d: got re=%0d im=%0d s=%0d k=%0d, expected re=%0d im=%0d s=%0d k=%0d",
          i, a_re, a_im, a_stage, a_index, dif_re_t[i], dif_im_t[i], i / 4, i % 4); end
    end
    @(negedge clk);
    n_tests++;
    if (a_done !== 1'b1 || a_busy !== 1'b0)
      begin n_fail++; $display("FAIL busy_start_done: got d=%0b b=%0b, expected 1 0", a_done, a_busy); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (a_valid !== 1'b1 || a_busy !== 1'b1 || a_done !== 1'b0 || a_re !== 12'sd1024 ||
        a_im !== 12'sd0 || a_stage !== 2'd0 || a_index !== 2'd0)
      begin n_fail++; $display("FAIL start_on_done: got v=%0b b=%0b d=%0b re=%0d im=%0d s=%0d k=%0d, expected 1 1 0 1024 0 0 0",
        a_valid, a_busy, a_done, a_re, a_im, a_stage, a_index); end
  endtask

  task automatic test_reset_mid();
    bit done_bad = 1'b0;
    do_reset();
    pulse_start();
    repeat (7) @(negedge clk);
    n_tests++;
    if (a_stage !== 2'd1 || a_index !== 2'd2 || a_valid !== 1'b1)
      begin n_fail++; $display("FAIL mid_position: got s=%0d k=%0d v=%0b, expected 1 2 1", a_stage, a_index, a_valid); end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({a_valid, a_busy, a_done, a_re, a_im, a_stage, a_index} !== '0)
      begin n_fail++; $display("FAIL async_reset: got v=%0b b=%0b d=%0b re=%0d im=%0d s=%0d k=%0d, expected all 0",
        a_valid, a_busy, a_done, a_re, a_im, a_stage, a_index); end
    repeat (2) begin @(negedge clk); done_bad |= a_done; end
    reset = 1'b0;
    repeat (3) begin @(negedge clk); done_bad |= a_done | a_valid; end
    n_tests++;
    if (done_bad)
      begin n_fail++; $display("FAIL reset_no_done: got done/valid activity=1, expected 0"); end
    pulse_start();
    @(negedge clk);
    n_tests++;
    if (a_valid !== 1'b1 || a_re !== 12'sd1024 || a_im !== 12'sd0 || a_stage !== 2'd0 || a_index !== 2'd0)
      begin n_fail++; $display("FAIL restart_after_reset: got v=%0b re=%0d im=%0d s=%0d k=%0d, expected 1 1024 0 0 0",
        a_valid, a_re, a_im, a_stage, a_index); end
  endtask

  task automatic test_log2n4();
    int cnt  = 0;
    bit seen = 1'b0;
    do_reset();
    pulse_start();
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (c_valid === 1'b1) begin
        if (cnt == 0) begin
          n_tests++;
          if (c_re !== 16'sd16384 || c_im !== 16'sd0 || c_index !== 3'd0)
            begin n_fail++; $display("FAIL n16_k0: got re=%0d im=%0d k=%0d, expected 16384 0 0", c_re, c_im, c_index); end
        end
        if (cnt == 3) begin
          n_tests++;
          if (c_re !== 16'sd6270 || c_im !== -16'sd15137 || c_stage !== 2'd0 || c_index !== 3'd3)
            begin n_fail++; $display("FAIL n16_k3: got re=%0d im=%0d s=%0d k=%0d, expected 6270 -15137 0 3",
              c_re, c_im, c_stage, c_index); end
        end
        if (cnt == 6) begin
          n_tests++;
          if (c_re !== -16'sd11585 || c_im !== -16'sd11585 || c_stage !== 2'd0 || c_index !== 3'd6)
            begin n_fail++; $display("FAIL n16_k6: got re=%0d im=%0d s=%0d k=%0d, expected -11585 -11585 0 6",
              c_re, c_im, c_stage, c_index); end
        end
        cnt++;
      end else if (c_done === 1'b1) begin
        seen = 1'b1;
      end
    end
    n_tests++;
    if (!seen || cnt != 32)
      begin n_fail++; $display("FAIL n16_frame_len: got done_seen=%0b transfers=%0d, expected 1 32", seen, cnt); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tw_ready = 1'b1;
    test_reset();
    test_dif();
    test_dit();
    test_back_pressure();
    test_start_ignored();
    test_reset_mid();
    test_log2n4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/twiddle_seq.md
Name: twiddle_seq

Overview:
Parametrised twiddle-factor sequencer for an N-point radix-2 FFT, N = 2^LOG2N. On a start pulse it streams one complex twiddle W_N^e = cos(2πe/N) − j·sin(2πe/N) per butterfly, for every stage of one frame. It uses a valid/ready handshake and replaces the fixed 8-point per-stage twiddle tables. It feeds the butterfly datapath and supports DIF or DIT stage ordering.

Parameters:
LOG2N, 3, log2 of FFT size; legal range 2..12.
WIDTH, 12, signed twiddle width; fixed point with FRAC = WIDTH−2 fraction bits, so +1.0 = 2^(WIDTH−2).
MODE, "DIF", exponent schedule, "DIF" or "DIT"; any other value is an elaboration error.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-high reset.
start  in  1  begin frame; sampled only when busy=0.
tw_ready  in  1  consumer accepts current twiddle.
tw_valid  out  1  tw_re/tw_im/tw_stage/tw_index hold a valid entry.
tw_re  out  WIDTH  signed real part.
tw_im  out  WIDTH  signed imaginary part.
tw_stage  out  max(1,clog2(LOG2N))  current stage s, 0..LOG2N−1.
tw_index  out  LOG2N−1  butterfly index k within stage, 0..N/2−1.
busy  out  1  frame in progress.
done  out  1  one-cycle pulse after last transfer.

Behaviour:
- Reset (async assert, any state): state IDLE; tw_valid=0, tw_re=0, tw_im=0, tw_stage=0, tw_index=0, busy=0, done=0; counters cleared. Reset mid-frame abandons the frame; no done pulse.
- FSM states:
  - IDLE: start=1 → RUN. Entry (s=0,k=0) is registered onto the outputs, tw_valid=1 and busy=1 from the next cycle.
  - RUN: a transfer is tw_valid & tw_ready.
    - On transfer, advance k. When k=N/2−1, wrap k to 0 and increment s.
    - The next entry appears the cycle after the transfer, with no bubbles; full throughput is one entry per cycle.
    - On transfer of (s=LOG2N−1, k=N/2−1): → IDLE. tw_valid=0, busy=0 and done=1 for exactly that next cycle.
  - Back-pressure: while tw_valid & !tw_ready, all outputs hold stable.
- Frame length is LOG2N·N/2 transfers.
- start while busy=1 is ignored. start in the cycle done=1 (busy=0) is accepted; the new frame's first entry appears one cycle later.
- Exponent e for stage s, index k:
  - DIF: e = (k mod 2^(LOG2N−1−s)) · 2^s.
  - DIT: e = (k mod 2^s) · 2^(LOG2N−1−s).
  - In both modes e < N/2.
- Table: quarter-wave cosine table C[i], i = 0..N/4.
  - C[i] = round(cos(2πi/N) · 2^FRAC), round half away from zero.
  - Contents are fixed at elaboration; no runtime loading.
- Twiddle reconstruction:
  - e < N/4: tw_re = C[e], tw_im = −C[N/4−e].
  - e ≥ N/4, with e' = e − N/4: tw_re = −C[N/4−e'], tw_im = −C[e'].
  - Negation of a zero entry yields 0. +1.0 (2^FRAC) fits in WIDTH bits; no saturation is needed.
- All outputs are registered; no combinational path from tw_ready to the outputs except through the flops.

Test Plan:
- LOG2N=3, WIDTH=12, DIF, tw_ready=1, pulse start → 12 consecutive transfers, starting one cycle after start:
  - s0: (1024,0), (724,−724), (0,−1024), (−724,−724).
  - s1: (1024,0), (0,−1024), (1024,0), (0,−1024).
  - s2: four times (1024,0).
  - Then done=1 for one cycle, busy=0.
- Same configuration with MODE="DIT" →
  - s0: four times (1024,0).
  - s1: (1024,0), (0,−1024), (1024,0), (0,−1024).
  - s2: (1024,0), (724,−724), (0,−1024), (−724,−724).
- Back-pressure: drop tw_ready for 3 cycles at s=1,k=1 → outputs held at (0,−1024,s1,k1) and tw_valid=1 for those cycles. Sequence then resumes unaltered; frame completes in 15 cycles total.
- start pulsed at s=0,k=2 mid-frame → ignored; sequence unchanged. start on the done cycle → second frame begins at (1024,0,s0,k0) one cycle later.
- Assert reset at s=1,k=2 → all outputs 0 asynchronously, no done pulse. A fresh start after reset release restarts at s0,k0.
- LOG2N=4, WIDTH=16, DIF → C = {16384, 15137, 11585, 6270, 0}. s0,k=3: e=3 → (6270,−15137). s0,k=6: e=6 → (−11585,−11585). Frame length is 32 transfers.
